loop_count_stack: RTL and testbench
===================================

Name: loop_count_stack

Overview:
- Hardware loop-count unit for the 16-bit processor datapath: a small LIFO of down-counters that holds loop iteration counts for nested loops.
- The control unit pushes a count on loop entry, decrements the top entry once per iteration, and pops it on loop exit.
- The branch logic reads the top count and its zero flag to decide whether to take the loop-back branch.
- It is the decrementing counterpart of the PC incrementor; its count arithmetic wraps neither up nor below zero.

Parameters:
WIDTH, 16, bit width of each count entry
DEPTH, 4, number of stack entries (power of two, at least 2)
PTR_W, 3, width of the depth output; must equal clog2(DEPTH)+1

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
load  input  1  push load_val as a new top entry
load_val  input  WIDTH  initial iteration count for the pushed entry
dec  input  1  decrement the top entry by 1
pop  input  1  discard the top entry
err_clr  input  1  clear the sticky err flag
count  output  WIDTH  value of the top entry; 0 when empty
zero  output  1  high when not empty and the top entry equals 0
depth  output  PTR_W  number of valid entries, from 0 to DEPTH
full  output  1  depth == DEPTH
empty  output  1  depth == 0
err  output  1  sticky flag for an illegal operation

Behaviour:
- All state updates on the rising edge of clk.
- count, zero, depth, full and empty are combinational from registered state, so they reflect an operation in the cycle after its edge.
- Reset (synchronous, active-high) overrides all other inputs:
  - depth=0, all entries=0, err=0.
  - Resulting outputs: count=0, zero=0, full=0, empty=1.
- Reset asserted mid-sequence discards every entry on that edge; no partial state survives.
- Command decode, evaluated once per edge in this priority order:
  1. pop and load together: replace the top entry with load_val; depth unchanged. If empty, behave as a plain load.
  2. load alone: if not full, write load_val to entry[depth] and depth+1. If full, the stack is unchanged and err=1.
  3. pop alone: if not empty, depth-1; the old top entry becomes don't-care. If empty, no change and err=1.
  4. dec alone: if not empty and top > 0, top becomes top-1. If top == 0, top holds at 0 and err=1 (no wrap to 0xFFFF). If empty, no change and err=1.
- dec asserted together with load or pop is ignored. The load/pop rule applies and err is not set by the dec.
- No-operation cycles hold all state.
- Entries below the top are never modified by dec.
- load_val of 0 is legal: after the push, zero=1.
- err is sticky. It clears on the edge where err_clr=1 and no new error occurs on that edge; if an error occurs on the same edge as err_clr, err stays 1. err never blocks normal operation.
- Arithmetic is unsigned WIDTH-bit; subtraction of 1 only.
- depth is a binary count, not a one-hot pointer.
- Storage is a register array; no memory macros.

Test Plan:
1. Reset, then load with load_val=3, then three dec cycles -> count sequence 3,2,1,0. zero=1 after the third dec; depth=1; err=0.
2. With top=0, issue dec -> count stays 0, err=1. Then err_clr -> err=0 on the next cycle.
3. Nested loops: load 5, load 2, dec, pop -> count shows 5,2,1,5; depth shows 1,2,2,1. The outer entry is still 5.
4. Fill the stack with 4 loads (values 10,11,12,13) -> full=1, depth=4. A fifth load of 99 -> count stays 13, err=1. Pop four times -> count 12,11,10,0, empty=1. A further pop -> err stays 1, depth=0.
5. With top=7, assert load_val=9 with pop=1 and load=1 together -> count=9, depth unchanged. Then pop+load+dec together with load_val=4 -> count=4, not 3.
6. Push 2 entries, then assert reset on the same edge as a load -> depth=0, empty=1, count=0, err=0. The load is discarded.

Source files
------------

// File: rtl/loop_count_stack.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | loop_count_stack                                                      |
// | LIFO of saturating down-counters holding nested loop iteration counts |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module loop_count_stack #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4,
   parameter int PTR_W = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             dec,
   input  logic             pop,
   input  logic             err_clr,
   output logic [WIDTH-1:0] count,
   output logic             zero,
   output logic [PTR_W-1:0] depth,
   output logic             full,
   output logic             empty,
   output logic             err
);

   localparam int IDX_W = $clog2(DEPTH);

   logic [WIDTH-1:0] stack_q [DEPTH];
   logic [WIDTH-1:0] stack_d [DEPTH];
   logic [PTR_W-1:0] depth_q, depth_d;
   logic             err_q, err_d;
   logic             w_err_event;
   logic [IDX_W-1:0] w_top_idx;
   logic [IDX_W-1:0] w_push_idx;
   logic             w_full, w_empty;
   logic [WIDTH-1:0] w_top;

   // Index arithmetic wraps mod DEPTH; it is only used when the stack is non-empty.
   assign w_push_idx = depth_q[IDX_W-1:0];
   assign w_top_idx  = depth_q[IDX_W-1:0] - IDX_W'(1);
   assign w_full     = (depth_q == PTR_W'(DEPTH));
   assign w_empty    = (depth_q == '0);
   assign w_top      = stack_q[w_top_idx];

   always_comb begin
      stack_d     = stack_q;
      depth_d     = depth_q;
      w_err_event = 1'b0;
      if (load && pop) begin
         if (w_empty) begin
            stack_d[0] = load_val;
            depth_d    = PTR_W'(1);
         end else begin
            stack_d[w_top_idx] = load_val;
         end
      end else if (load) begin
         if (w_full) begin
            w_err_event = 1'b1;
         end else begin
            stack_d[w_push_idx] = load_val;
            depth_d             = depth_q + PTR_W'(1);
         end
      end else if (pop) begin
         if (w_empty) begin
            w_err_event = 1'b1;
         end else begin
            depth_d = depth_q - PTR_W'(1);
         end
      end else if (dec) begin
         // Counts saturate at zero rather than wrapping.
         if (w_empty || (w_top == '0)) begin
            w_err_event = 1'b1;
         end else begin
            stack_d[w_top_idx] = w_top - WIDTH'(1);
         end
      end
      err_d = w_err_event | (err_q & ~err_clr);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            stack_q[i] <= '0;
         end
         depth_q <= '0;
         err_q   <= 1'b0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            stack_q[i] <= stack_d[i];
         end
         depth_q <= depth_d;
         err_q   <= err_d;
      end
   end

   assign count = w_empty ? '0 : w_top;
   assign zero  = !w_empty && (w_top == '0);
   assign depth = depth_q;
   assign full  = w_full;
   assign empty = w_empty;
   assign err   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_loop_count_stack.sv
`default_nettype none
// Directed bench for loop_count_stack: each task drives a scenario and checks
// outputs one time unit after the clock edge against hand-derived values.
module tb_loop_count_stack;

   logic        clk;
   logic        reset;
   logic        load;
   logic [15:0] load_val;
   logic        dec;
   logic        pop;
   logic        err_clr;
   logic [15:0] count;
   logic        zero;
   logic [2:0]  depth;
   logic        full;
   logic        empty;
   logic        err;

   int tests_run;
   int tests_failed;

   loop_count_stack #(.WIDTH(16), .DEPTH(4), .PTR_W(3)) dut (
      .clk      (clk),
      .reset    (reset),
      .load     (load),
      .load_val (load_val),
      .dec      (dec),
      .pop      (pop),
      .err_clr  (err_clr),
      .count    (count),
      .zero     (zero),
      .depth    (depth),
      .full     (full),
      .empty    (empty),
      .err      (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Apply one command for exactly one rising edge, then return to idle.
   task automatic cycle(input logic l, input logic [15:0] v, input logic p,
                        input logic d, input logic c, input logic r);
      load = l; load_val = v; pop = p; dec = d; err_clr = c; reset = r;
      @(posedge clk);
      #1;
      load = 1'b0; load_val = 16'd0; pop = 1'b0; dec = 1'b0; err_clr = 1'b0; reset = 1'b0;
   endtask

   task automatic test_reset();
      cycle(0, 0, 0, 0, 0, 1);
      tests_run++;
      if ({count, zero, depth, full, empty, err} !== {16'd0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0}) begin
         tests_failed++;
         $display("FAIL reset_state: count=%0d zero=%0b depth=%0d full=%0b empty=%0b err=%0b, expected 0 0 0 0 1 0",
                  count, zero, depth, full, empty, err);
      end
   endtask

   task automatic test_count_down();
      logic [15:0] exp_seq [4];
      exp_seq = '{16'd3, 16'd2, 16'd1, 16'd0};
      cycle(1, 16'd3, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) begin
         if (i > 0) cycle(0, 0, 0, 1, 0, 0);
         tests_run++;
         if (count !== exp_seq[i]) begin
            tests_failed++;
            $display("FAIL countdown_%0d: count=%0d expected %0d", i, count, exp_seq[i]);
         end
      end
      tests_run++;
      if ({zero, depth, err} !== {1'b1, 3'd1, 1'b0}) begin
         tests_failed++;
         $display("FAIL countdown_flags: zero=%0b depth=%0d err=%0b expected 1 1 0", zero, depth, err);
      end
   endtask

   task automatic test_dec_underflow();
      cycle(0, 0, 0, 1, 0, 0);
      tests_run++;
      if ({count, zero, err} !== {16'd0, 1'b1, 1'b1}) begin
         tests_failed++;
         $display("FAIL dec_at_zero: count=%0d zero=%0b err=%0b expected 0 1 1", count, zero, err);
      end
      cycle(0, 0, 0, 0, 1, 0);
      tests_run++;
      if (err !== 1'b0) begin
         tests_failed++;
         $display("FAIL err_clr: err=%0b expected 0", err);
      end
      cycle(0, 0, 1, 0, 0, 0);
      cycle(0, 0, 0, 1, 0, 0);
      tests_run++;
      if ({err, depth, count} !== {1'b1, 3'd0, 16'd0}) begin
         tests_failed++;
         $display("FAIL dec_empty: err=%0b depth=%0d count=%0d expected 1 0 0", err, depth, count);
      end
   endtask

   task automatic test_nested();
      logic [15:0] exp_cnt [4];
      logic [2:0]  exp_dep [4];
      exp_cnt = '{16'd5, 16'd2, 16'd1, 16'd5};
      exp_dep = '{3'd1, 3'd2, 3'd2, 3'd1};
      cycle(0, 0, 0, 0, 0, 1);
      for (int i = 0; i < 4; i++) begin
         case (i)
            0: cycle(1, 16'd5, 0, 0, 0, 0);
            1: cycle(1, 16'd2, 0, 0, 0, 0);
            2: cycle(0, 0, 0, 1, 0, 0);
            default: cycle(0, 0, 1, 0, 0, 0);
         endcase
         tests_run++;
         if ({count, depth} !== {exp_cnt[i], exp_dep[i]}) begin
            tests_failed++;
            $display("FAIL nested_%0d: count=%0d depth=%0d expected %0d %0d",
                     i, count, depth, exp_cnt[i], exp_dep[i]);
         end
      end
   endtask

   task automatic test_fill_overflow();
      logic [15:0] exp_pop [4];
      exp_pop = '{16'd12, 16'd11, 16'd10, 16'd0};
      cycle(0, 0, 0, 0, 0, 1);
      for (int i = 0; i < 4; i++) cycle(1, 16'(10 + i), 0, 0, 0, 0);
      tests_run++;
      if ({full, depth, count, err} !== {1'b1, 3'd4, 16'd13, 1'b0}) begin
         tests_failed++;
         $display("FAIL fill: full=%0b depth=%0d count=%0d err=%0b expected 1 4 13 0", full, depth, count, err);
      end
      cycle(1, 16'd99, 0, 0, 0, 0);
      tests_run++;
      if ({count, depth, err} !== {16'd13, 3'd4, 1'b1}) begin
         tests_failed++;
         $display("FAIL overflow: count=%0d depth=%0d err=%0b expected 13 4 1", count, depth, err);
      end
      for (int i = 0; i < 4; i++) begin
         cycle(0, 0, 1, 0, 0, 0);
         tests_run++;
         if (count !== exp_pop[i]) begin
            tests_failed++;
            $display("FAIL drain_%0d: count=%0d expected %0d", i, count, exp_pop[i]);
         end
      end
      tests_run++;
      if ({empty, full} !== 2'b10) begin
         tests_failed++;
         $display("FAIL drained: empty=%0b full=%0b expected 1 0", empty, full);
      end
      // Error on the same edge as err_clr keeps err set.
      cycle(0, 0, 1, 0, 1, 0);
      tests_run++;
      if ({err, depth} !== {1'b1, 3'd0}) begin
         tests_failed++;
         $display("FAIL underflow_with_clr: err=%0b depth=%0d expected 1 0", err, depth);
      end
   endtask

   task automatic test_pop_load();
      cycle(0, 0, 0, 0, 0, 1);
      cycle(0, 0, 1, 0, 0, 0);
      cycle(1, 16'd6, 1, 0, 1, 0);
      tests_run++;
      if ({count, depth, err} !== {16'd6, 3'd1, 1'b0}) begin
         tests_failed++;
         $display("FAIL pop_load_empty: count=%0d depth=%0d err=%0b expected 6 1 0", count, depth, err);
      end
      cycle(1, 16'd7, 1, 0, 0, 0);
      cycle(1, 16'd9, 1, 0, 0, 0);
      tests_run++;
      if ({count, depth} !== {16'd9, 3'd1}) begin
         tests_failed++;
         $display("FAIL pop_load_replace: count=%0d depth=%0d expected 9 1", count, depth);
      end
      cycle(1, 16'd4, 1, 1, 0, 0);
      tests_run++;
      if ({count, depth, err} !== {16'd4, 3'd1, 1'b0}) begin
         tests_failed++;
         $display("FAIL pop_load_dec: count=%0d depth=%0d err=%0b expected 4 1 0", count, depth, err);
      end
      cycle(1, 16'd0, 0, 1, 0, 0);
      tests_run++;
      if ({count, zero, depth, err} !== {16'd0, 1'b1, 3'd2, 1'b0}) begin
         tests_failed++;
         $display("FAIL load_dec_zero: count=%0d zero=%0b depth=%0d err=%0b expected 0 1 2 0",
                  count, zero, depth, err);
      end
   endtask

   task automatic test_back_to_back_reset();
      cycle(0, 0, 0, 0, 0, 1);
      cycle(0, 0, 1, 0, 0, 0);
      cycle(1, 16'd1, 0, 0, 0, 0);
      cycle(1, 16'd2, 0, 0, 0, 0);
      tests_run++;
      if ({depth, count, err} !== {3'd2, 16'd2, 1'b1}) begin
         tests_failed++;
         $display("FAIL pre_reset: depth=%0d count=%0d err=%0b expected 2 2 1", depth, count, err);
      end
      cycle(1, 16'd8, 0, 0, 0, 1);
      tests_run++;
      if ({depth, empty, count, err, zero} !== {3'd0, 1'b1, 16'd0, 1'b0, 1'b0}) begin
         tests_failed++;
         $display("FAIL reset_with_load: depth=%0d empty=%0b count=%0d err=%0b zero=%0b expected 0 1 0 0 0",
                  depth, empty, count, err, zero);
      end
      cycle(0, 0, 0, 0, 0, 0);
      tests_run++;
      if ({depth, count} !== {3'd0, 16'd0}) begin
         tests_failed++;
         $display("FAIL idle_after_reset: depth=%0d count=%0d expected 0 0", depth, count);
      end
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      reset = 1'b1; load = 1'b0; load_val = 16'd0; dec = 1'b0; pop = 1'b0; err_clr = 1'b0;
      @(posedge clk);
      #1;
      test_reset();
      test_count_down();
      test_dec_underflow();
      test_nested();
      test_fill_overflow();
      test_pop_load();
      test_back_to_back_reset();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
`default_nettype wire
